// File: rtl/lieat_sram_rd_arb_pkg.sv
// Shared widths, arbiter state encoding and pointer-width helper for the
// lieat SRAM read arbiter.
package lieat_sram_rd_arb_pkg;

   localparam int LIEAT_ADDR_W = 32;
   localparam int LIEAT_DATA_W = 64;
   localparam int LIEAT_ID_W   = 4;
   localparam int LIEAT_SIZE_W = 3;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ADDR = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

   // A single requester still gets a 1-bit (constant zero) pointer.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lieat_sram_rd_arb_if.sv
// Requester-side AR/R bundle plus the SRAM read channel, seen by the arbiter
// through the slave modport and by the surrounding logic through master.
interface lieat_sram_rd_arb_if
   import lieat_sram_rd_arb_pkg::*;
#(
   parameter int N = 2
);
   logic [N-1:0]              m_arvalid;
   logic [N-1:0]              m_arready;
   logic [LIEAT_ADDR_W*N-1:0] m_araddr;
   logic [LIEAT_SIZE_W*N-1:0] m_arsize;
   logic [LIEAT_ID_W*N-1:0]   m_arid;
   logic [N-1:0]              m_rvalid;
   logic [N-1:0]              m_rready;
   logic [LIEAT_DATA_W-1:0]   m_rdata;
   logic [LIEAT_ID_W-1:0]     m_rid;

   logic                      sram_axi_arvalid;
   logic                      sram_axi_arready;
   logic [LIEAT_ADDR_W-1:0]   sram_axi_araddr;
   logic [LIEAT_SIZE_W-1:0]   sram_axi_arsize;
   logic [LIEAT_ID_W-1:0]     sram_axi_arid;
   logic                      sram_axi_rvalid;
   logic                      sram_axi_rready;
   logic [LIEAT_DATA_W-1:0]   sram_axi_rdata;
   logic [LIEAT_ID_W-1:0]     sram_axi_rid;

   modport slave (
      input  m_arvalid, m_araddr, m_arsize, m_arid, m_rready,
      input  sram_axi_arready, sram_axi_rvalid, sram_axi_rdata, sram_axi_rid,
      output m_arready, m_rvalid, m_rdata, m_rid,
      output sram_axi_arvalid, sram_axi_araddr, sram_axi_arsize, sram_axi_arid,
      output sram_axi_rready
   );

   modport master (
      output m_arvalid, m_araddr, m_arsize, m_arid, m_rready,
      output sram_axi_arready, sram_axi_rvalid, sram_axi_rdata, sram_axi_rid,
      input  m_arready, m_rvalid, m_rdata, m_rid,
      input  sram_axi_arvalid, sram_axi_araddr, sram_axi_arsize, sram_axi_arid,
      input  sram_axi_rready
   );

endinterface

// File: rtl/lieat_rr_picker.sv
// Combinational rotating priority encoder: the first set request at or after
// ptr (wrapping mod N) wins; returns a one-hot grant and its index.
module lieat_rr_picker #(
   parameter int N     = 2,
   parameter int PTR_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] index,
   output logic             found
);

   logic [2*N-1:0] req_dbl;
   logic [2*N-1:0] grant_dbl;
   logic [N-1:0]   rot;
   logic [N-1:0]   rot_oh;
   int             offset;
   int             sum;

   assign req_dbl = {req, req};
   assign rot     = N'(req_dbl >> ptr);
   assign found   = |req;

   // Lowest set bit of the rotated vector is the winner, relative to ptr.
   always_comb begin
      rot_oh = '0;
      offset = 0;
      for (int j = N - 1; j >= 0; j--) begin
         if (rot[j]) begin
            rot_oh    = '0;
            rot_oh[j] = 1'b1;
            offset    = j;
         end
      end
   end

   assign grant_dbl = {{N{1'b0}}, rot_oh} << ptr;
   assign grant     = grant_dbl[N-1:0] | grant_dbl[2*N-1:N];

   always_comb begin
      sum = offset + int'(ptr);
      if (sum >= N) begin
         sum = sum - N;
      end
      index = PTR_W'(sum);
   end

endmodule

// File: rtl/lieat_sram_rd_arb.sv
// Round-robin arbiter of N read requesters onto the single lieat_sram read
// channel, one read outstanding. Define LIEAT_ARB_FIXPRIO_EN for fixed priority.
module lieat_sram_rd_arb
   import lieat_sram_rd_arb_pkg::*;
#(
   parameter int N = 2
) (
   input  logic               clock,
   input  logic               reset,
   lieat_sram_rd_arb_if.slave bus
);

   localparam int PTR_W = ptr_width(N);

   arb_state_t              state_reg, state_next;
   logic [PTR_W-1:0]        ptr_reg;
   logic [N-1:0]            owner_reg, owner_next;
   logic [LIEAT_ADDR_W-1:0] addr_reg, addr_next;
   logic [LIEAT_SIZE_W-1:0] size_reg, size_next;
   logic [LIEAT_ID_W-1:0]   id_reg, id_next;

   logic [N-1:0]            req;
   logic [N-1:0]            win_oh;
   logic                    win_found;
   logic [LIEAT_ADDR_W-1:0] sel_addr;
   logic [LIEAT_SIZE_W-1:0] sel_size;
   logic [LIEAT_ID_W-1:0]   sel_id;
   logic                    r_fire;

   assign req = (state_reg == ARB_IDLE) ? bus.m_arvalid : '0;

`ifdef LIEAT_ARB_FIXPRIO_EN
   assign ptr_reg = '0;

   lieat_rr_picker #(.N(N), .PTR_W(PTR_W)) u_picker (
      .req   (req),
      .ptr   (ptr_reg),
      .grant (win_oh),
      .index (),
      .found (win_found)
   );
`else
   logic [PTR_W-1:0] win_idx;
   logic [PTR_W-1:0] owner_idx_reg, owner_idx_next;
   logic [PTR_W-1:0] ptr_next;

   lieat_rr_picker #(.N(N), .PTR_W(PTR_W)) u_picker (
      .req   (req),
      .ptr   (ptr_reg),
      .grant (win_oh),
      .index (win_idx),
      .found (win_found)
   );

   // Priority rotates to just past the owner once its response completes.
   always_comb begin
      owner_idx_next = owner_idx_reg;
      ptr_next       = ptr_reg;
      if (state_reg == ARB_IDLE && win_found) begin
         owner_idx_next = win_idx;
      end
      if (state_reg == ARB_RESP && r_fire) begin
         ptr_next = (owner_idx_reg == PTR_W'(N - 1)) ? '0 : owner_idx_reg + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr_reg       <= '0;
         owner_idx_reg <= '0;
      end else begin
         ptr_reg       <= ptr_next;
         owner_idx_reg <= owner_idx_next;
      end
   end
`endif

   always_comb begin
      sel_addr = '0;
      sel_size = '0;
      sel_id   = '0;
      for (int i = 0; i < N; i++) begin
         if (win_oh[i]) begin
            sel_addr = bus.m_araddr[i*LIEAT_ADDR_W +: LIEAT_ADDR_W];
            sel_size = bus.m_arsize[i*LIEAT_SIZE_W +: LIEAT_SIZE_W];
            sel_id   = bus.m_arid[i*LIEAT_ID_W +: LIEAT_ID_W];
         end
      end
   end

   // Grant is gated by reset so every output is quiet while reset is held.
   assign bus.m_arready = reset ? win_oh : '0;

   assign bus.sram_axi_arvalid = (state_reg == ARB_ADDR);
   assign bus.sram_axi_araddr  = addr_reg;
   assign bus.sram_axi_arsize  = size_reg;
   assign bus.sram_axi_arid    = id_reg;

   assign bus.sram_axi_rready = (state_reg == ARB_RESP) && (|(owner_reg & bus.m_rready));
   assign bus.m_rvalid        = (state_reg == ARB_RESP) ? (owner_reg & {N{bus.sram_axi_rvalid}}) : '0;
   assign bus.m_rdata         = bus.sram_axi_rdata;
   assign bus.m_rid           = bus.sram_axi_rid;

   assign r_fire = bus.sram_axi_rvalid && bus.sram_axi_rready;

   always_comb begin
      state_next = state_reg;
      owner_next = owner_reg;
      addr_next  = addr_reg;
      size_next  = size_reg;
      id_next    = id_reg;
      case (state_reg)
         ARB_IDLE: begin
            if (win_found) begin
               state_next = ARB_ADDR;
               owner_next = win_oh;
               addr_next  = sel_addr;
               size_next  = sel_size;
               id_next    = sel_id;
            end
         end
         ARB_ADDR: begin
            if (bus.sram_axi_arready) begin
               state_next = ARB_RESP;
            end
         end
         ARB_RESP: begin
            if (r_fire) begin
               state_next = ARB_IDLE;
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= ARB_IDLE;
         owner_reg <= '0;
         addr_reg  <= '0;
         size_reg  <= '0;
         id_reg    <= '0;
      end else begin
         state_reg <= state_next;
         owner_reg <= owner_next;
         addr_reg  <= addr_next;
         size_reg  <= size_next;
         id_reg    <= id_next;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clock) begin
      if (reset) begin
         assert (state_reg == ARB_RESP || !bus.sram_axi_rvalid)
            else $warning("lieat_sram_rd_arb: sram_axi_rvalid outside RESP ignored");
      end
   end
`endif

endmodule

// File: tb/tb_lieat_sram_rd_arb.sv
// Bench for lieat_sram_rd_arb: directed scenarios with literal expectations,
// then random traffic checked every cycle against a transaction-level model.
module tb_lieat_sram_rd_arb;
   import lieat_sram_rd_arb_pkg::*;

   localparam int N = 2;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   grants[$];
   logic pend = 1'b0;
   logic [3:0] pend_id = '0;

   lieat_sram_rd_arb_if #(.N(N)) bus ();

   lieat_sram_rd_arb #(.N(N)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: at most one read in flight; phase 0 waiting, 1 address out,
   // 2 awaiting response. Winner is first valid requester searching from ptr.
   int mph = 0, mptr = 0, mown = 0, w;
   logic [31:0]  maddr;
   logic [2:0]   msize;
   logic [3:0]   mid;
   logic [N-1:0] e_arready, e_rvalid;

   always @(negedge clock or negedge reset) begin
      if (!reset) begin
         mph = 0; mptr = 0; mown = 0; maddr = '0; msize = '0; mid = '0;
      end else begin
         e_arready = '0;
         w = -1;
         if (mph == 0) begin
            for (int k = 0; k < N; k++) begin
               int c;
               c = (mptr + k) % N;
               if (w < 0 && bus.m_arvalid[c]) w = c;
            end
         end
         if (w >= 0) e_arready[w] = 1'b1;
         e_rvalid = '0;
         if (mph == 2 && bus.sram_axi_rvalid) e_rvalid[mown] = 1'b1;
         chk("m_arready", bus.m_arready, e_arready);
         chk("m_rvalid", bus.m_rvalid, e_rvalid);
         chk("sram_arvalid", bus.sram_axi_arvalid, mph == 1);
         chk("sram_rready", bus.sram_axi_rready, mph == 2 && bus.m_rready[mown]);
         if (mph == 1) begin
            chk("sram_araddr", bus.sram_axi_araddr, maddr);
            chk("sram_arsize", bus.sram_axi_arsize, msize);
            chk("sram_arid", bus.sram_axi_arid, mid);
         end
         if (|e_rvalid) begin
            chk("m_rdata", bus.m_rdata, bus.sram_axi_rdata);
            chk("m_rid", bus.m_rid, bus.sram_axi_rid);
         end
         case (mph)
            0: if (w >= 0) begin
               mown = w;
               maddr = bus.m_araddr[w*32 +: 32];
               msize = bus.m_arsize[w*3 +: 3];
               mid = bus.m_arid[w*4 +: 4];
               mph = 1;
            end
            1: if (bus.sram_axi_arready) mph = 2;
            2: if (bus.sram_axi_rvalid && bus.m_rready[mown]) begin
               mph = 0;
`ifndef LIEAT_ARB_FIXPRIO_EN
               mptr = (mown + 1) % N;
`endif
            end
            default: mph = 0;
         endcase
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic new_req(input int i);
      bus.m_arvalid[i] = 1'b1;
      bus.m_araddr[i*32 +: 32] = $urandom;
      bus.m_arsize[i*3 +: 3] = 3'($urandom_range(0, 3));
      bus.m_arid[i*4 +: 4] = 4'($urandom);
   endtask

   // One clock of the requester/SRAM environment; rnd=0 is zero-wait, held.
   task automatic do_cycle(input bit auto_req, input bit rnd);
      logic [N-1:0] hs;
      logic arh, rh;
      @(negedge clock);
      hs = bus.m_arvalid & bus.m_arready;
      arh = bus.sram_axi_arvalid & bus.sram_axi_arready;
      rh = bus.sram_axi_rvalid & bus.sram_axi_rready;
      for (int i = 0; i < N; i++) if (hs[i]) grants.push_back(i);
      tick();
      if (rh) bus.sram_axi_rvalid = 1'b0;
      if (arh) begin pend = 1'b1; pend_id = bus.sram_axi_arid; end
      if (!bus.sram_axi_rvalid && pend && (!rnd || $urandom_range(0, 2) != 0)) begin
         bus.sram_axi_rvalid = 1'b1;
         bus.sram_axi_rdata = {$urandom, $urandom};
         bus.sram_axi_rid = pend_id;
         pend = 1'b0;
      end
      bus.sram_axi_arready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.m_rready = rnd ? N'($urandom) : '1;
      if (auto_req) begin
         for (int i = 0; i < N; i++) begin
            if (hs[i] || !bus.m_arvalid[i]) begin
               if (!rnd || $urandom_range(0, 3) == 0) new_req(i);
               else bus.m_arvalid[i] = 1'b0;
            end
         end
      end
   endtask

   int exp_order[4];
   int g0;

   initial begin
      bus.m_arvalid = '1; bus.m_araddr = '0; bus.m_arsize = '0; bus.m_arid = '0;
      bus.m_rready = '0; bus.sram_axi_arready = 1'b0; bus.sram_axi_rvalid = 1'b0;
      bus.sram_axi_rdata = '0; bus.sram_axi_rid = '0;
      #2;
      chk("rst_m_arready", bus.m_arready, 2'b00);
      chk("rst_arvalid", bus.sram_axi_arvalid, 1'b0);
      bus.m_arvalid = '0;
      repeat (2) @(posedge clock);
      #3 reset = 1'b1;
      @(negedge clock);
      chk("rst_araddr", bus.sram_axi_araddr, 32'h0);
      chk("rst_m_rvalid", bus.m_rvalid, 2'b00);
      chk("rst_rready", bus.sram_axi_rready, 1'b0);

      // Single request from requester 0.
      tick();
      bus.m_arvalid = 2'b01; bus.m_araddr[31:0] = 32'h8000_0010;
      bus.m_arid[3:0] = 4'd3; bus.m_arsize[2:0] = 3'd3; bus.sram_axi_arready = 1'b1;
      bus.m_rready = 2'b11;
      @(negedge clock); chk("single_grant", bus.m_arready, 2'b01);
      tick(); bus.m_arvalid = '0;
      @(negedge clock);
      chk("single_araddr", bus.sram_axi_araddr, 32'h8000_0010);
      chk("single_arid", bus.sram_axi_arid, 4'd3);
      tick(); bus.sram_axi_rvalid = 1'b1; bus.sram_axi_rdata = 64'hDEAD_BEEF_0123_4567; bus.sram_axi_rid = 4'd3;
      @(negedge clock);
      chk("single_rvalid", bus.m_rvalid, 2'b01);
      chk("single_rdata", bus.m_rdata, 64'hDEAD_BEEF_0123_4567);
      tick(); bus.sram_axi_rvalid = 1'b0;
      @(negedge clock);
      chk("single_idle_rvalid", bus.m_rvalid, 2'b00);
      chk("single_idle_arvalid", bus.sram_axi_arvalid, 1'b0);

      // Both requesters held from reset.
      tick(); reset = 1'b0; #2 reset = 1'b1;
      grants.delete(); pend = 1'b0;
      new_req(0); new_req(1);
      repeat (14) do_cycle(1'b1, 1'b0);
`ifdef LIEAT_ARB_FIXPRIO_EN
      exp_order = '{0, 0, 0, 0};
`else
      exp_order = '{0, 1, 0, 1};
`endif
      chk("order_count", grants.size() >= 4, 1'b1);
      for (int i = 0; i < 4 && i < grants.size(); i++) chk("grant_order", grants[i], exp_order[i]);
      bus.m_arvalid = '0;
      repeat (6) do_cycle(1'b0, 1'b0);
      bus.sram_axi_rvalid = 1'b0;

      // SRAM address stall, then R back-pressure on owner 1.
      bus.sram_axi_arready = 1'b0; bus.m_arvalid = 2'b10;
      bus.m_araddr[63:32] = 32'h1234_5678; bus.m_arsize[5:3] = 3'd2; bus.m_arid[7:4] = 4'd7;
      @(negedge clock); chk("stall_grant", bus.m_arready, 2'b10);
      tick(); bus.m_arvalid = 2'b01;
      repeat (5) begin
         @(negedge clock);
         chk("stall_arvalid", bus.sram_axi_arvalid, 1'b1);
         chk("stall_araddr", bus.sram_axi_araddr, 32'h1234_5678);
         chk("stall_arsize", bus.sram_axi_arsize, 3'd2);
         chk("stall_arid", bus.sram_axi_arid, 4'd7);
         chk("stall_m_arready", bus.m_arready, 2'b00);
         tick();
      end
      bus.sram_axi_arready = 1'b1;
      @(negedge clock); tick();
      bus.sram_axi_arready = 1'b0; bus.sram_axi_rvalid = 1'b1;
      bus.sram_axi_rdata = 64'h0BAD_F00D_CAFE_0001; bus.sram_axi_rid = 4'd7; bus.m_rready = 2'b00;
      repeat (4) begin
         @(negedge clock);
         chk("bp_rready", bus.sram_axi_rready, 1'b0);
         chk("bp_m_rvalid", bus.m_rvalid, 2'b10);
         tick();
      end
      bus.m_rready = 2'b10;
      @(negedge clock);
      chk("bp_release_rready", bus.sram_axi_rready, 1'b1);
      chk("bp_release_rid", bus.m_rid, 4'd7);
      tick(); bus.sram_axi_rvalid = 1'b0; bus.m_arvalid = 2'b11;
      @(negedge clock); chk("ptr0_grant", bus.m_arready, 2'b01);

      // Reset while in RESP.
      tick(); bus.m_arvalid = 2'b00; bus.sram_axi_arready = 1'b1;
      @(negedge clock); tick();
      bus.sram_axi_arready = 1'b0; bus.sram_axi_rvalid = 1'b1; bus.m_rready = 2'b00;
      @(negedge clock); chk("resp_before_rst", bus.m_rvalid, 2'b01);
      bus.m_arvalid = 2'b11;
      #2 reset = 1'b0;
      #1;
      chk("async_rst_m_rvalid", bus.m_rvalid, 2'b00);
      chk("async_rst_arready", bus.m_arready, 2'b00);
      chk("async_rst_rready", bus.sram_axi_rready, 1'b0);
      chk("async_rst_araddr", bus.sram_axi_araddr, 32'h0);
      bus.sram_axi_rvalid = 1'b0; bus.m_arvalid = 2'b00;
      #1 reset = 1'b1;
      tick(); bus.m_arvalid = 2'b10;
      @(negedge clock); chk("post_rst_grant", bus.m_arready, 2'b10);
      tick(); bus.m_arvalid = 2'b00; pend = 1'b0;
      repeat (6) do_cycle(1'b0, 1'b0);
      bus.sram_axi_rvalid = 1'b0;

      // Spurious SRAM response while idle.
      bus.sram_axi_rvalid = 1'b1; bus.m_rready = 2'b11;
      repeat (2) begin
         @(negedge clock);
         chk("spur_m_rvalid", bus.m_rvalid, 2'b00);
         chk("spur_rready", bus.sram_axi_rready, 1'b0);
         tick();
      end
      bus.sram_axi_rvalid = 1'b0;

      // Random traffic against the model.
      pend = 1'b0;
      g0 = grants.size();
      repeat (3000) do_cycle(1'b1, 1'b1);
      chk("random_progress", grants.size() > g0 + 100, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lieat_sram_rd_arb.md
Name: lieat_sram_rd_arb

Overview:
- Arbitrates N read requesters (default 2: instruction fetch, load unit) onto the single read channel of the lieat_sram port (sram_axi_ar*/r*).
- Only one read is outstanding at a time.
- The winner's AR is captured into registers, issued to the SRAM, and its single-beat R response is routed back to the owner only.
- Sits between requesters and lieat_sram, alongside the existing write path, which it does not touch.

Parameters:
N, 2, number of read requesters (N >= 1)

Ports:
clock  input  1  core clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
m_arvalid  input  N  per-requester AR valid
m_arready  output  N  per-requester AR ready; one-hot or zero
m_araddr  input  32*N  packed AR addresses, requester i at [32i+31:32i]
m_arsize  input  3*N  packed AR sizes
m_arid  input  4*N  packed AR IDs
m_rvalid  output  N  per-requester R valid; one-hot or zero
m_rready  input  N  per-requester R ready
m_rdata  output  64  broadcast R data, qualified by m_rvalid
m_rid  output  4  broadcast R ID, qualified by m_rvalid
sram_axi_arvalid  output  1  AR valid to SRAM
sram_axi_arready  input  1  AR ready from SRAM
sram_axi_araddr  output  32  registered address
sram_axi_arsize  output  3  registered size
sram_axi_arid  output  4  registered ID (requester's ID, unmodified)
sram_axi_rvalid  input  1  R valid from SRAM
sram_axi_rready  output  1  R ready to SRAM
sram_axi_rdata  input  64  R data from SRAM
sram_axi_rid  input  4  R ID from SRAM

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, ptr=0, owner=0, addr/size/id regs=0.
  - sram_axi_arvalid=0, sram_axi_rready=0, m_arready=0, m_rvalid=0.
  - A transaction in flight is abandoned; lieat_sram shares the reset.
- IDLE:
  - Winner = first i with m_arvalid[i]=1, searching ptr, ptr+1, … mod N.
  - m_arready[winner]=1 in the same cycle (combinational from m_arvalid and state only).
  - On that handshake: latch owner, addr, size, id; next state ADDR.
  - With no requests: stay in IDLE, all m_arready=0.
- ADDR:
  - sram_axi_arvalid=1 with latched fields, held stable until sram_axi_arready.
  - All m_arready=0.
  - On arvalid & arready: next state RESP.
- RESP:
  - m_rvalid[owner]=sram_axi_rvalid; other bits 0.
  - sram_axi_rready=m_rready[owner].
  - m_rdata=sram_axi_rdata, m_rid=sram_axi_rid.
  - On sram_axi_rvalid & sram_axi_rready: ptr = (owner==N-1) ? 0 : owner+1; next state IDLE.
- Latency:
  - Request accepted in cycle t; sram_axi_arvalid first high in cycle t+1.
  - Response accepted in cycle k; next grant possible in cycle k+1.
  - Peak throughput is one read per 3 cycles with a zero-wait SRAM.
- Single-beat reads only; there is no rlast on the SRAM side.
- sram_axi_rvalid outside RESP: ignored, rready stays 0; simulation assertion fires.
- Requesters not granted keep their valid and payload stable; no starvation within N grants (round-robin).
- ptr width is max(1, $clog2(N)); with N=1, ptr is constant 0 and the winner is always requester 0.
- Back-pressure: m_rready[owner]=0 holds the SRAM response; the block does not buffer R.

Optional Feature:
- LIEAT_ARB_FIXPRIO_EN defined: fixed priority, lowest index wins; ptr is not updated and stays 0. Requester 0 (fetch) may starve others.
- Undefined: round-robin as above.
- Ports and all other timing are identical in both modes.

Decomposition:
- lieat_defines.v holds LIEAT_ADDR_W=32, LIEAT_DATA_W=64, LIEAT_ID_W=4, LIEAT_SIZE_W=3, and the state encodings ARB_IDLE=2'd0, ARB_ADDR=2'd1, ARB_RESP=2'd2.
- Registers use lieat_general_dff.v flops with async active-low reset.
- One sub-module: lieat_rr_picker, a combinational rotating priority encoder.
  - Inputs: req[N], ptr.
  - Outputs: one-hot grant, index.
  - The FIXPRIO build ties ptr=0.

Test Plan:
- Single request: m_arvalid=01, addr0=0x8000_0010, id0=3, SRAM arready immediate, rvalid 1 cycle later with rdata=0xDEAD_BEEF_0123_4567 -> m_arready=01 at t0, sram_axi_araddr=0x8000_0010 and arid=3 at t1, m_rvalid=01 with that rdata, then IDLE.
- Simultaneous requests, both held: m_arvalid=11 from reset -> grant order 0,1,0,1; m_rvalid never goes to the non-owner. Under LIEAT_ARB_FIXPRIO_EN, order is 0,0,0,…
- SRAM stalls: sram_axi_arready=0 for 5 cycles -> arvalid, araddr, arsize, arid stable all 5 cycles; m_arready=00 throughout.
- R back-pressure: owner 1, m_rready=00 for 4 cycles with sram rvalid=1 -> sram_axi_rready=0, m_rvalid=10 held; release -> completes, ptr=0.
- Reset mid-op: assert reset=0 in RESP -> outputs 0 immediately, without waiting for a clock edge; after release, a new request from requester 1 is granted normally.
- Spurious sram_axi_rvalid=1 in IDLE -> no m_rvalid, sram_axi_rready=0, assertion reported.
